// File: rtl/usr_pkg.sv
// Shared mode encoding, controller states and mode classification for the
// universal shift register.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Only the bit-moving modes can be repeated by the multi-step operation.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_bit_stage.sv
// One register bit: selects its next value from itself, a neighbour,
// the load bit or zero, and holds it in a flop with asynchronous reset.
module usr_bit_stage
    import usr_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] mode_i,
    input  logic       d_i,
    input  logic       lo_i,
    input  logic       hi_i,
    output logic       q_o
);

    logic bit_q, bit_d;

    // lo_i is the bit arriving from below (left shifts), hi_i from above.
    always_comb begin
        bit_d = bit_q;
        case (mode_i)
            MODE_HOLD:  bit_d = bit_q;
            MODE_LOAD:  bit_d = d_i;
            MODE_SHL:   bit_d = lo_i;
            MODE_ROL:   bit_d = lo_i;
            MODE_SHR:   bit_d = hi_i;
            MODE_ROR:   bit_d = hi_i;
            MODE_ASR:   bit_d = hi_i;
            MODE_CLEAR: bit_d = 1'b0;
            default:    bit_d = bit_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) bit_q <= RESET_BIT;
        else       bit_q <= bit_d;
    end

    assign q_o = bit_q;

endmodule

// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: single-step ops in IDLE and a
// counted multi-step shift/rotate with start/busy/done handshake.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CNT_W       = $clog2(WIDTH) + 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic [2:0]       op_mode;
    logic [WIDTH-1:0] q_w, lo_w, hi_w;

    // op_mode is what the bit stages apply this edge; HOLD means no change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        op_mode = MODE_HOLD;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift_mode(mode)) begin
                        if (amount != '0) begin
                            state_d = ST_RUN;
                            cnt_d   = amount;
                            mode_d  = mode;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        op_mode = mode;
                        done_d  = 1'b1;
                    end
                end else if (en) begin
                    op_mode = mode;
                end
            end
            ST_RUN: begin
                op_mode = mode_q;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // End stages pick serial input or wrap bit depending on the mode.
        if (i == 0) begin : g_lsb
            assign lo_w[i] = (op_mode == MODE_ROL) ? q_w[WIDTH-1] : sin_r;
        end else begin : g_lo
            assign lo_w[i] = q_w[i-1];
        end
        if (i == WIDTH - 1) begin : g_msb
            assign hi_w[i] = (op_mode == MODE_SHR) ? sin_l :
                             (op_mode == MODE_ROR) ? q_w[0] : q_w[WIDTH-1];
        end else begin : g_hi
            assign hi_w[i] = q_w[i+1];
        end

        usr_bit_stage #(
            .RESET_BIT(RESET_VALUE[i])
        ) u_stage (
            .clock (clock),
            .reset (reset),
            .mode_i(op_mode),
            .d_i   (d[i]),
            .lo_i  (lo_w[i]),
            .hi_i  (hi_w[i]),
            .q_o   (q_w[i])
        );
    end

    assign q      = q_w;
    assign sout_l = q_w[WIDTH-1];
    assign sout_r = q_w[0];
    assign busy   = (state_q == ST_RUN);
    assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed scenarios plus randomized traffic, all checked every cycle
// against an arithmetic reference model of the register.
module tb_universal_shift_register;

    localparam int         W     = 8;
    localparam int         CW    = $clog2(W) + 2;
    localparam logic [7:0] RVAL  = 8'hA5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0, sin_l = 1'b0, sin_r = 1'b0, start = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic [W-1:0]  d = '0;
    logic [CW-1:0] amount = '0;
    logic [W-1:0]  q;
    logic          sout_l, sout_r, busy, done;

    int n_chk = 0;
    int n_err = 0;

    universal_shift_register #(.WIDTH(W), .RESET_VALUE(RVAL)) dut (
        .clock(clock), .reset(reset), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .start(start), .amount(amount),
        .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One step of a mode on an 8-bit value, in plain integer arithmetic.
    function automatic int f_step(input int v, input int m, input int d_v,
                                  input int sl, input int sr);
        case (m)
            0: return v;
            1: return d_v;
            2: return ((v * 2) + sr) % 256;
            3: return (v / 2) + sl * 128;
            4: return ((v * 2) % 256) + (v / 128);
            5: return (v / 2) + (v % 2) * 128;
            6: return (v / 2) + (v / 128) * 128;
            default: return 0;
        endcase
    endfunction

    int m_q, m_mode, m_left;
    bit m_busy, m_done;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_q <= RVAL; m_busy <= 0; m_done <= 0; m_left <= 0; m_mode <= 0;
        end else begin
            m_done <= 0;
            if (m_busy) begin
                m_q    <= f_step(m_q, m_mode, 0, sin_l, sin_r);
                m_left <= m_left - 1;
                if (m_left == 1) begin m_busy <= 0; m_done <= 1; end
            end else if (start) begin
                if (mode >= 2 && mode <= 6) begin
                    if (amount == 0) m_done <= 1;
                    else begin m_busy <= 1; m_left <= amount; m_mode <= mode; end
                end else begin
                    m_q <= f_step(m_q, mode, d, sin_l, sin_r);
                    m_done <= 1;
                end
            end else if (en) begin
                m_q <= f_step(m_q, mode, d, sin_l, sin_r);
            end
        end
    end

    always @(negedge clock) begin
        check("q", q, m_q);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("sout_l", sout_l, m_q / 128);
        check("sout_r", sout_r, m_q % 2);
    end

    task automatic idle_in();
        en = 0; start = 0; mode = 3'd0;
    endtask

    task automatic single(input int m, input int dv, input int sl, input int sr);
        en = 1; mode = 3'(m); d = 8'(dv); sin_l = sl[0]; sin_r = sr[0];
        @(negedge clock);
        idle_in();
    endtask

    initial begin
        @(negedge clock);
        check("reset_q", q, 8'hA5);
        check("reset_busy", busy, 0);
        reset = 0;

        // Reset in the middle of a SHL by 5.
        start = 1; mode = 3'd2; amount = 5; sin_r = 1;
        @(negedge clock); start = 0; mode = 3'd1;
        @(negedge clock);
        @(negedge clock);
        check("mid_run_busy", busy, 1);
        #2 reset = 1;
        #1;
        check("async_rst_q", q, 8'hA5);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        @(negedge clock); reset = 0;
        @(negedge clock);
        check("no_resume_busy", busy, 0);

        // Single steps.
        single(1, 8'h81, 0, 0);
        single(4, 0, 0, 0);
        check("rol_81", q, 8'h03);
        single(1, 8'h80, 0, 0);
        single(6, 0, 0, 0);
        check("asr_80", q, 8'hC0);
        single(7, 0, 0, 0);
        single(3, 0, 1, 0);
        check("shr_sinl", q, 8'h80);

        // Multi-step ROR by 3 with junk on mode/d while running.
        single(1, 8'h01, 0, 0);
        start = 1; mode = 3'd5; amount = 3;
        @(negedge clock); start = 0; mode = 3'd7; d = 8'hFF; en = 1; amount = 1;
        check("ror_busy0", busy, 1);
        @(negedge clock); check("ror_busy1", busy, 1);
        @(negedge clock); check("ror_busy2", busy, 1);
        @(negedge clock); idle_in();
        check("ror_q", q, 8'h20);
        check("ror_done", done, 1);
        check("ror_busy_end", busy, 0);
        @(negedge clock); check("ror_done_clr", done, 0);

        // amount = 0 and amount > WIDTH.
        start = 1; mode = 3'd4; amount = 0;
        @(negedge clock); start = 0;
        check("amt0_q", q, 8'h20);
        check("amt0_done", done, 1);
        check("amt0_busy", busy, 0);
        start = 1; mode = 3'd2; amount = 9; sin_r = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); start = 0;
        end
        check("shl9_q", q, 8'hFF);
        check("shl9_done", done, 1);

        // start beats en; back-to-back start in the done cycle.
        start = 1; en = 1; mode = 3'd1; d = 8'h3C; sin_r = 0;
        @(negedge clock); en = 0;
        check("pri_q", q, 8'h3C);
        check("pri_done", done, 1);
        start = 1; mode = 3'd2; amount = 2;
        @(negedge clock); start = 0; check("b2b_busy0", busy, 1);
        @(negedge clock); check("b2b_busy1", busy, 1);
        @(negedge clock);
        check("b2b_q", q, 8'hF0);
        check("b2b_done", done, 1);

        // Serial out while shifting a single one out of the top.
        single(1, 8'h80, 0, 0);
        start = 1; mode = 3'd2; amount = 8; sin_r = 0;
        @(negedge clock); start = 0;
        check("sout_first", sout_l, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("sout_later", sout_l, 0);
        end
        check("ser_q", q, 8'h00);
        check("ser_done", done, 1);

        // Randomized traffic, including occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            en     = 1'($urandom_range(0, 1));
            start  = ($urandom_range(0, 5) == 0);
            mode   = 3'($urandom);
            d      = 8'($urandom);
            sin_l  = 1'($urandom);
            sin_r  = 1'($urandom);
            amount = CW'($urandom_range(0, 12));
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1;
                #1 reset = 0;
            end
        end
        @(negedge clock); idle_in();
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
